// File: rtl/fcmp_pkg.sv
// Shared definitions for the floating-point compare arbiter: op and state
// encodings plus IEEE-754 field widths derived from the operand width.
package fcmp_pkg;

  localparam int DEFAULT_BUS_WIDTH = 32'd64;

  typedef enum logic [1:0] {
    FCMP_FEQ = 2'b00,
    FCMP_FLT = 2'b01,
    FCMP_FLE = 2'b10,
    FCMP_FGE = 2'b11
  } fcmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } fcmp_state_e;

  function automatic int mantissa_size(input int bus_width);
    return (bus_width == 32'd32) ? 32'd23 : 32'd52;
  endfunction

  function automatic int exponent_size(input int bus_width);
    return bus_width - 32'd1 - mantissa_size(bus_width);
  endfunction

  localparam int MANTISSA_SIZE = mantissa_size(DEFAULT_BUS_WIDTH);
  localparam int EXPONENT_SIZE = exponent_size(DEFAULT_BUS_WIDTH);

endpackage

// File: rtl/fcmp_arbiter_if.sv
// Request/response bundle between the two requesters and the compare arbiter.
interface fcmp_arbiter_if #(
  parameter int BUS_WIDTH = 64
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [3:0]             req_op;
  logic [2*BUS_WIDTH-1:0] req_a;
  logic [2*BUS_WIDTH-1:0] req_b;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_id;
  logic [BUS_WIDTH-1:0]   resp_data;
  logic                   resp_nv;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data, resp_nv
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data, resp_nv
  );
endinterface

// File: rtl/fcmp_core.sv
// Combinational IEEE-754 compare: FEQ/FLT/FLE/FGE with RISC-V NaN and NV rules.
module fcmp_core
  import fcmp_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  fcmp_op_e             op,
  output logic                 lt,
  output logic                 eq,
  output logic                 nan,
  output logic                 snan,
  output logic                 result,
  output logic                 nv
);
  localparam int MW = mantissa_size(BUS_WIDTH);
  localparam int EW = exponent_size(BUS_WIDTH);

  logic                 a_sign_s, b_sign_s;
  logic [EW-1:0]        a_exp_s, b_exp_s;
  logic [MW-1:0]        a_man_s, b_man_s;
  logic [BUS_WIDTH-2:0] a_mag_s, b_mag_s;
  logic                 a_nan_s, b_nan_s, a_snan_s, b_snan_s;
  logic                 zeros_s;

  assign a_sign_s = a[BUS_WIDTH-1];
  assign b_sign_s = b[BUS_WIDTH-1];
  assign a_exp_s  = a[BUS_WIDTH-2 -: EW];
  assign b_exp_s  = b[BUS_WIDTH-2 -: EW];
  assign a_man_s  = a[MW-1:0];
  assign b_man_s  = b[MW-1:0];
  assign a_mag_s  = a[BUS_WIDTH-2:0];
  assign b_mag_s  = b[BUS_WIDTH-2:0];

  // Quiet NaNs have the mantissa MSB set; signalling ones do not.
  assign a_nan_s  = (&a_exp_s) & (|a_man_s);
  assign b_nan_s  = (&b_exp_s) & (|b_man_s);
  assign a_snan_s = a_nan_s & ~a_man_s[MW-1];
  assign b_snan_s = b_nan_s & ~b_man_s[MW-1];
  assign nan      = a_nan_s | b_nan_s;
  assign snan     = a_snan_s | b_snan_s;
  assign zeros_s  = ~(|a_mag_s) & ~(|b_mag_s);
  assign eq       = ~nan & ((a == b) | zeros_s);

  // Ordered less-than; negative magnitudes order in reverse.
  always_comb begin
    lt = 1'b0;
    if (nan || zeros_s) begin
      lt = 1'b0;
    end else if (a_sign_s != b_sign_s) begin
      lt = a_sign_s;
    end else if (!a_sign_s) begin
      lt = (a_mag_s < b_mag_s);
    end else begin
      lt = (b_mag_s < a_mag_s);
    end
  end

  // Result and invalid flag per operation.
  always_comb begin
    result = 1'b0;
    nv     = nan;
    case (op)
      FCMP_FEQ: begin result = eq;              nv = snan; end
      FCMP_FLT: begin result = lt;              nv = nan;  end
      FCMP_FLE: begin result = lt | eq;         nv = nan;  end
      FCMP_FGE: begin result = ~nan & ~lt;      nv = nan;  end
      default:  begin result = 1'b0;            nv = nan;  end
    endcase
  end
endmodule

// File: rtl/fcmp_arbiter.sv
// Two-requester round-robin front end for a shared FP compare core,
// with one captured operand set and one registered response.
module fcmp_arbiter
  import fcmp_pkg::*;
#(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
  parameter int NUM_REQ   = 2
) (
  input logic           clk,
  input logic           rst,
  fcmp_arbiter_if.slave bus
);
  fcmp_state_e          state_r, state_next_s;
  logic                 last_grant_r;
  logic                 id_r;
  fcmp_op_e             op_r;
  logic [BUS_WIDTH-1:0] a_r, b_r;
  logic                 resp_valid_r, resp_id_r, resp_nv_r;
  logic [BUS_WIDTH-1:0] resp_data_r;

  logic [NUM_REQ-1:0]   grant_s;
  logic                 win_id_s;
  logic                 handshake_s;
  logic                 core_lt_s, core_eq_s, core_nan_s, core_snan_s;
  logic                 core_result_s, core_nv_s;
  logic                 core_flags_unused_s;

  // Round-robin winner: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    win_id_s = 1'b0;
    grant_s  = 2'b00;
    if (bus.req_valid == 2'b11) begin
      win_id_s = ~last_grant_r;
    end else if (bus.req_valid[1]) begin
      win_id_s = 1'b1;
    end else begin
      win_id_s = 1'b0;
    end
    if (|bus.req_valid) begin
      grant_s = win_id_s ? 2'b10 : 2'b01;
    end else begin
      grant_s = 2'b00;
    end
  end

  assign bus.req_ready = (state_r == IDLE) ? grant_s : 2'b00;
  assign handshake_s   = (state_r == IDLE) & (|grant_s);

  fcmp_core #(.BUS_WIDTH(BUS_WIDTH)) u_core (
    .a      (a_r),
    .b      (b_r),
    .op     (op_r),
    .lt     (core_lt_s),
    .eq     (core_eq_s),
    .nan    (core_nan_s),
    .snan   (core_snan_s),
    .result (core_result_s),
    .nv     (core_nv_s)
  );
  assign core_flags_unused_s = ^{core_lt_s, core_eq_s, core_nan_s, core_snan_s};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) state_next_s = EXEC;
        else             state_next_s = IDLE;
      end
      EXEC: state_next_s = RESP;
      RESP: begin
        if (bus.resp_ready) state_next_s = IDLE;
        else                state_next_s = RESP;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, round-robin pointer and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      op_r         <= FCMP_FEQ;
      a_r          <= '0;
      b_r          <= '0;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_data_r  <= '0;
      resp_nv_r    <= 1'b0;
    end else begin
      if (handshake_s) begin
        last_grant_r <= win_id_s;
        id_r         <= win_id_s;
        op_r         <= fcmp_op_e'(win_id_s ? bus.req_op[3:2] : bus.req_op[1:0]);
        a_r          <= win_id_s ? bus.req_a[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_a[BUS_WIDTH-1:0];
        b_r          <= win_id_s ? bus.req_b[2*BUS_WIDTH-1:BUS_WIDTH] : bus.req_b[BUS_WIDTH-1:0];
      end
      if (state_r == EXEC) begin
        resp_valid_r <= 1'b1;
        resp_id_r    <= id_r;
        resp_data_r  <= {{(BUS_WIDTH-1){1'b0}}, core_result_s};
        resp_nv_r    <= core_nv_s;
      end else if ((state_r == RESP) && bus.resp_ready) begin
        resp_valid_r <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_id    = resp_id_r;
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_nv    = resp_nv_r;
endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed scoreboard bench for fcmp_arbiter: arbitration, latency, NaN/zero rules, back-pressure, reset.
module tb_fcmp_arbiter;
  import fcmp_pkg::*;

  localparam int BW = 64;
  localparam logic [63:0] ONE   = 64'h3FF0000000000000;
  localparam logic [63:0] TWO   = 64'h4000000000000000;
  localparam logic [63:0] MONE  = 64'hBFF0000000000000;
  localparam logic [63:0] MTWO  = 64'hC000000000000000;
  localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
  localparam logic [63:0] SNAN  = 64'h7FF4000000000000;
  localparam logic [63:0] PZERO = 64'h0000000000000000;
  localparam logic [63:0] NZERO = 64'h8000000000000000;

  typedef struct packed {
    logic        id;
    logic [63:0] data;
    logic        nv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  fcmp_arbiter_if #(.BUS_WIDTH(BW)) bus ();

  fcmp_arbiter #(.BUS_WIDTH(BW), .NUM_REQ(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    bus.req_valid[id]        = 1'b1;
    bus.req_op[id*2 +: 2]    = op;
    bus.req_a[id*BW +: BW]   = a;
    bus.req_b[id*BW +: BW]   = b;
  endtask

  task automatic clear(input int id);
    bus.req_valid[id] = 1'b0;
  endtask

  // Wait for a grant, check which requester gets it, and record the expected response.
  task automatic grant(input string tag, input logic [1:0] exp_ready,
                       input logic [63:0] exp_data, input logic exp_nv);
    int n;
    exp_t e;
    n = 0;
    #1;
    while (bus.req_ready === 2'b00 && n < 10) begin
      step();
      n++;
    end
    check({tag, "_grant_wait"}, 64'(n < 10), 64'd1);
    check({tag, "_req_ready"}, 64'(bus.req_ready), 64'(exp_ready));
    e.id   = exp_ready[1];
    e.data = exp_data;
    e.nv   = exp_nv;
    sb_q.push_back(e);
    step();
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall, then consume.
  task automatic respond(input string tag, input int hold);
    int n;
    exp_t e;
    n = 0;
    #1;
    while (bus.resp_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check({tag, "_resp_wait"}, 64'(n < 10), 64'd1);
    e = sb_q.pop_front();
    check({tag, "_id"},   64'(bus.resp_id), 64'(e.id));
    check({tag, "_data"}, bus.resp_data,    e.data);
    check({tag, "_nv"},   64'(bus.resp_nv), 64'(e.nv));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_hold_data"},  bus.resp_data,       e.data);
      check({tag, "_hold_ready"}, 64'(bus.req_ready),  64'd0);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check({tag, "_consumed"}, 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.req_valid  = 2'b00;
    bus.req_op     = 4'h0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    rst            = 1'b1;

    // Reset state
    do_reset();
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_data",  bus.resp_data,        64'd0);
    check("rst_resp_id",    64'(bus.resp_id),     64'd0);
    check("rst_resp_nv",    64'(bus.resp_nv),     64'd0);
    check("rst_req_ready",  64'(bus.req_ready),   64'd0);

    // Single request with latency check
    drive(0, 2'b01, ONE, TWO);
    grant("flt_1_2", 2'b01, 64'd1, 1'b0);
    clear(0);
    check("lat_exec_valid", 64'(bus.resp_valid), 64'd0);
    step();
    check("lat_resp_valid", 64'(bus.resp_valid), 64'd1);
    respond("flt_1_2", 0);

    // Both requesting after reset: 0, then 1, then 0 again
    do_reset();
    drive(0, 2'b11, TWO, ONE);
    drive(1, 2'b00, ONE, ONE);
    grant("both_r0", 2'b01, 64'd1, 1'b0);
    check("busy_req_ready", 64'(bus.req_ready), 64'd0);
    respond("both_r0", 0);
    grant("both_r1", 2'b10, 64'd1, 1'b0);
    respond("both_r1", 0);
    grant("both_r0b", 2'b01, 64'd1, 1'b0);
    clear(0);
    clear(1);
    respond("both_r0b", 0);

    // NaN, signed-zero and ordering cases
    drive(0, 2'b00, QNAN, ONE);  grant("feq_qnan", 2'b01, 64'd0, 1'b0); clear(0); respond("feq_qnan", 0);
    drive(1, 2'b00, SNAN, ONE);  grant("feq_snan", 2'b10, 64'd0, 1'b1); clear(1); respond("feq_snan", 0);
    drive(0, 2'b10, QNAN, ONE);  grant("fle_qnan", 2'b01, 64'd0, 1'b1); clear(0); respond("fle_qnan", 0);
    drive(1, 2'b00, PZERO, NZERO); grant("feq_zero", 2'b10, 64'd1, 1'b0); clear(1); respond("feq_zero", 0);
    drive(0, 2'b01, MONE, NZERO); grant("flt_m1_m0", 2'b01, 64'd1, 1'b0); clear(0); respond("flt_m1_m0", 0);
    drive(1, 2'b01, TWO, ONE);   grant("flt_2_1", 2'b10, 64'd0, 1'b0); clear(1); respond("flt_2_1", 0);
    drive(0, 2'b10, MTWO, MONE); grant("fle_neg", 2'b01, 64'd1, 1'b0); clear(0); respond("fle_neg", 0);
    drive(1, 2'b11, MTWO, MONE); grant("fge_neg", 2'b10, 64'd0, 1'b0); clear(1); respond("fge_neg", 0);
    drive(0, 2'b01, PZERO, NZERO); grant("flt_zero", 2'b01, 64'd0, 1'b0); clear(0); respond("flt_zero", 0);

    // Back-pressure: a new request must wait while the response is held
    drive(1, 2'b01, ONE, TWO);
    grant("hold", 2'b10, 64'd1, 1'b0);
    clear(1);
    drive(0, 2'b11, ONE, ONE);
    respond("hold", 5);
    grant("after_hold", 2'b01, 64'd1, 1'b0);
    clear(0);
    respond("after_hold", 0);

    // Reset while executing drops the op
    drive(0, 2'b00, ONE, ONE);
    grant("rst_exec", 2'b01, 64'd1, 1'b0);
    clear(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(sb_q.pop_back());
    check("rst_exec_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_exec_ready", 64'(bus.req_ready),  64'd0);
    step();
    step();
    check("rst_exec_dropped", 64'(bus.resp_valid), 64'd0);
    drive(1, 2'b01, MONE, NZERO);
    grant("post_rst_r1", 2'b10, 64'd1, 1'b0);
    clear(1);
    respond("post_rst_r1", 0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
